// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: opcodes, fixed operand addresses and FSM states for sys_cmd_ctrl
package sys_ctrl_pkg;
    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
    localparam int ADDR_OPA = 0;
    localparam int ADDR_OPB = 1;
    typedef enum logic [3:0] {
        ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT, ST_RD_PUSH,
        ST_OPA, ST_OPB, ST_FUN, ST_GATE, ST_ALU_WAIT, ST_PUSH_LO, ST_PUSH_HI
    } state_e;
endpackage

// File: rtl/sys_ctrl_tx_push.sv
// sys_ctrl_tx_push: full-aware registered write port into the TX FIFO
module sys_ctrl_tx_push #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  full_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  accept_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_vld_o
);
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_vld_q;
    assign accept_o  = req_i & ~full_i;
    assign tx_data_o = tx_data_q;
    assign tx_vld_o  = tx_vld_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
        end else begin
            tx_vld_q <= accept_o;
            if (accept_o) tx_data_q <= data_i;
        end
    end
endmodule

// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: UART command sequencer driving register file, ALU, clock gate and TX FIFO
module sys_cmd_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4,
    parameter int ALU_OUT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
    input  logic                     RF_RD_DATA_VLD,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    input  logic                     FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]    RF_ADDR,
    output logic                     RF_WR_EN,
    output logic                     RF_RD_EN,
    output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
    output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    output logic                     ALU_EN,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     CTRL_BUSY
);
    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    rf_addr_q, rf_addr_d;
    logic                     rf_wr_en_q, rf_wr_en_d;
    logic                     rf_rd_en_q, rf_rd_en_d;
    logic [DATA_WIDTH-1:0]    rf_wr_data_q, rf_wr_data_d;
    logic [ALU_FUN_WIDTH-1:0] alu_fun_q, alu_fun_d;
    logic                     alu_en_q, alu_en_d;
    logic                     gate_q, gate_d;
    logic                     busy_q;
    logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
    logic [ALU_OUT_WIDTH-1:0] res_q, res_d;
    logic                     push_req, push_acc;
    logic [DATA_WIDTH-1:0]    push_data;

    assign push_req  = state_q inside {ST_RD_PUSH, ST_PUSH_LO, ST_PUSH_HI};
    assign push_data = state_q == ST_PUSH_LO ? res_q[DATA_WIDTH-1:0] :
                       state_q == ST_PUSH_HI ? res_q[ALU_OUT_WIDTH-1:DATA_WIDTH] : rd_data_q;

    sys_ctrl_tx_push #(.DATA_WIDTH(DATA_WIDTH)) u_push (
        .clk_i    (CLK),
        .rst_i    (RST),
        .req_i    (push_req),
        .full_i   (FIFO_FULL),
        .data_i   (push_data),
        .accept_o (push_acc),
        .tx_data_o(TX_P_DATA),
        .tx_vld_o (TX_D_VLD)
    );

    always_comb begin
        state_d      = state_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rf_wr_data_d = rf_wr_data_q;
        alu_fun_d    = alu_fun_q;
        alu_en_d     = 1'b0;
        gate_d       = gate_q;
        rd_data_d    = rd_data_q;
        res_d        = res_q;
        case (state_q)
            ST_IDLE: if (RX_D_VLD)
                state_d = RX_P_DATA == CMD_RF_WR   ? ST_WR_ADDR :
                          RX_P_DATA == CMD_RF_RD   ? ST_RD_ADDR :
                          RX_P_DATA == CMD_ALU_OP  ? ST_OPA :
                          RX_P_DATA == CMD_ALU_NOP ? ST_FUN : ST_IDLE;
            ST_WR_ADDR: if (RX_D_VLD) begin
                rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                state_d   = ST_WR_DATA;
            end
            ST_WR_DATA: if (RX_D_VLD) begin
                rf_wr_en_d   = 1'b1;
                rf_wr_data_d = RX_P_DATA;
                state_d      = ST_IDLE;
            end
            ST_RD_ADDR: if (RX_D_VLD) begin
                rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                rf_rd_en_d = 1'b1;
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: if (RF_RD_DATA_VLD) begin
                rd_data_d = RF_RD_DATA;
                state_d   = ST_RD_PUSH;
            end
            ST_RD_PUSH: if (push_acc) state_d = ST_IDLE;
            ST_OPA, ST_OPB: if (RX_D_VLD) begin
                rf_addr_d    = ADDR_WIDTH'(state_q == ST_OPA ? ADDR_OPA : ADDR_OPB);
                rf_wr_en_d   = 1'b1;
                rf_wr_data_d = RX_P_DATA;
                state_d      = state_q == ST_OPA ? ST_OPB : ST_FUN;
            end
            ST_FUN: if (RX_D_VLD) begin
                alu_fun_d = RX_P_DATA[ALU_FUN_WIDTH-1:0];
                gate_d    = 1'b1;
                state_d   = ST_GATE;
            end
            ST_GATE: begin
                alu_en_d = 1'b1;
                state_d  = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: if (ALU_OUT_VLD) begin
                res_d   = ALU_OUT;
                gate_d  = 1'b0;
                state_d = ST_PUSH_LO;
            end
            ST_PUSH_LO: if (push_acc) state_d = ST_PUSH_HI;
            ST_PUSH_HI: if (push_acc) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            rf_addr_q    <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_wr_data_q <= '0;
            alu_fun_q    <= '0;
            alu_en_q     <= 1'b0;
            gate_q       <= 1'b0;
            busy_q       <= 1'b0;
            rd_data_q    <= '0;
            res_q        <= '0;
        end else begin
            state_q      <= state_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_fun_q    <= alu_fun_d;
            alu_en_q     <= alu_en_d;
            gate_q       <= gate_d;
            busy_q       <= state_d != ST_IDLE;
            rd_data_q    <= rd_data_d;
            res_q        <= res_d;
        end
    end

    assign RF_ADDR     = rf_addr_q;
    assign RF_WR_EN    = rf_wr_en_q;
    assign RF_RD_EN    = rf_rd_en_q;
    assign RF_WR_DATA  = rf_wr_data_q;
    assign ALU_FUN     = alu_fun_q;
    assign ALU_EN      = alu_en_q;
    assign CLK_GATE_EN = gate_q;
    assign CTRL_BUSY   = busy_q;
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb_sys_cmd_ctrl: directed self-checking bench for sys_cmd_ctrl
module tb_sys_cmd_ctrl;
    logic        CLK = 1'b0, RST = 1'b1;
    logic [7:0]  RX_P_DATA = '0, RF_RD_DATA = '0;
    logic        RX_D_VLD = 1'b0, RF_RD_DATA_VLD = 1'b0, ALU_OUT_VLD = 1'b0, FIFO_FULL = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic [3:0]  RF_ADDR, ALU_FUN;
    logic [7:0]  RF_WR_DATA, TX_P_DATA;
    logic        RF_WR_EN, RF_RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD, CTRL_BUSY;
    int n_chk = 0, n_fail = 0;
    int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, en_cnt = 0;

    sys_cmd_ctrl dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL),
        .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
        .RF_WR_DATA(RF_WR_DATA), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .CTRL_BUSY(CTRL_BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RF_WR_EN) wr_cnt <= wr_cnt + 1;
        if (RF_RD_EN) rd_cnt <= rd_cnt + 1;
        if (TX_D_VLD) tx_cnt <= tx_cnt + 1;
        if (ALU_EN)   en_cnt <= en_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    function automatic logic [31:0] all_out();
        return {2'b0, RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_FUN, ALU_EN,
                CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CTRL_BUSY};
    endfunction

    initial begin
        int w0, t0;
        tick(); tick();
        chk("reset_outputs", all_out(), 0);
        RST = 1'b0;

        // register write AA,05,FF
        send(8'hAA);
        chk("wr_busy", CTRL_BUSY, 1);
        send(8'h05);
        chk("wr_addr", RF_ADDR, 5);
        chk("wr_no_early_strobe", RF_WR_EN, 0);
        send(8'hFF);
        chk("wr_strobe", RF_WR_EN, 1);
        chk("wr_data", RF_WR_DATA, 8'hFF);
        chk("wr_addr_hold", RF_ADDR, 5);
        chk("wr_idle", CTRL_BUSY, 0);
        tick();
        chk("wr_strobe_one_cycle", RF_WR_EN, 0);
        chk("wr_pulse_count", wr_cnt, 1);

        // register read BB,02 -> 0x21
        send(8'hBB);
        send(8'h02);
        chk("rd_strobe", RF_RD_EN, 1);
        chk("rd_addr", RF_ADDR, 2);
        tick();
        chk("rd_strobe_one_cycle", RF_RD_EN, 0);
        RF_RD_DATA = 8'h21; RF_RD_DATA_VLD = 1'b1;
        tick();
        RF_RD_DATA_VLD = 1'b0;
        chk("rd_no_early_push", TX_D_VLD, 0);
        tick();
        chk("rd_push_vld", TX_D_VLD, 1);
        chk("rd_push_data", TX_P_DATA, 8'h21);
        chk("rd_idle", CTRL_BUSY, 0);
        tick();
        chk("rd_push_one_cycle", TX_D_VLD, 0);
        chk("rd_counts", {rd_cnt[15:0], tx_cnt[15:0]}, {16'd1, 16'd1});

        // ALU op CC,0F,05,01 -> 0x000A
        send(8'hCC);
        send(8'h0F);
        chk("opa_strobe", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'd0, 8'h0F});
        send(8'h05);
        chk("opb_strobe", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'd1, 8'h05});
        send(8'h01);
        chk("fun_latch", ALU_FUN, 1);
        chk("gate_open_first", {CLK_GATE_EN, ALU_EN}, 2'b10);
        tick();
        chk("alu_start", {CLK_GATE_EN, ALU_EN}, 2'b11);
        tick();
        chk("alu_start_one_cycle", {CLK_GATE_EN, ALU_EN}, 2'b10);
        ALU_OUT = 16'h000A; ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        chk("gate_closed", CLK_GATE_EN, 0);
        tick();
        chk("push_lo", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h0A});
        tick();
        chk("push_hi", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h00});
        chk("alu_idle", CTRL_BUSY, 0);
        tick();
        chk("alu_counts", {wr_cnt[7:0], tx_cnt[7:0], en_cnt[7:0]}, {8'd3, 8'd3, 8'd1});
        chk("fun_held", ALU_FUN, 1);

        // stray byte in IDLE
        w0 = wr_cnt; t0 = tx_cnt;
        send(8'h3C);
        chk("stray_idle", CTRL_BUSY, 0);
        tick();
        chk("stray_no_strobes", {RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD}, 0);

        // ALU without operands, byte during ALU_WAIT, FIFO full for 5 cycles in PUSH_LO
        send(8'hDD);
        send(8'h00);
        chk("nop_fun", {ALU_FUN, CLK_GATE_EN}, {4'd0, 1'b1});
        tick();
        chk("nop_alu_en", ALU_EN, 1);
        send(8'hAA);
        chk("drop_in_wait", {CTRL_BUSY, CLK_GATE_EN, RF_WR_EN, ALU_EN}, 4'b1100);
        FIFO_FULL = 1'b1;
        ALU_OUT = 16'h000A; ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("full_hold_%0d", i), TX_D_VLD, 0);
        end
        FIFO_FULL = 1'b0;
        tick();
        chk("full_push_lo", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h0A});
        tick();
        chk("full_push_hi", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h00});
        tick();
        chk("full_push_count", tx_cnt - t0, 2);
        chk("no_stray_writes", wr_cnt - w0, 0);
        chk("full_idle", CTRL_BUSY, 0);

        // reset mid-command then fresh read
        send(8'hAA);
        send(8'h05);
        RST = 1'b1;
        tick();
        chk("abort_outputs", all_out(), 0);
        RST = 1'b0;
        send(8'hFF);
        chk("abort_no_write", {RF_WR_EN, CTRL_BUSY}, 0);
        send(8'hBB);
        send(8'h05);
        chk("fresh_read", {RF_RD_EN, RF_ADDR}, {1'b1, 4'd5});
        tick();
        RF_RD_DATA = 8'h5A; RF_RD_DATA_VLD = 1'b1;
        tick();
        RF_RD_DATA_VLD = 1'b0;
        tick();
        chk("fresh_push", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h5A});
        tick();
        chk("abort_write_count", wr_cnt - w0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
Command sequencer between the UART RX/TX path and the register file / ALU datapath. It decodes framed command bytes from the RX synchronizer:
- 0xAA register write
- 0xBB register read
- 0xCC ALU operation with operands
- 0xDD ALU operation without operands

It drives the register file, the ALU and the ALU clock-gate enable, then pushes results into the TX async FIFO. It lives in the REF_CLK domain.

Parameters:
DATA_WIDTH, 8, RX/TX byte and register-file data width
ADDR_WIDTH, 4, register-file address width
ALU_FUN_WIDTH, 4, ALU function code width
ALU_OUT_WIDTH, 16, ALU result width; fixed at 2*DATA_WIDTH

Ports:
CLK  in  1  REF_CLK domain clock
RST  in  1  synchronous, active-high reset
RX_P_DATA  in  DATA_WIDTH  synchronized received byte
RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
RF_RD_DATA  in  DATA_WIDTH  register-file read data
RF_RD_DATA_VLD  in  1  read data valid pulse
ALU_OUT  in  ALU_OUT_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid pulse
FIFO_FULL  in  1  TX FIFO full
RF_ADDR  out  ADDR_WIDTH  register-file address
RF_WR_EN  out  1  write strobe (one cycle)
RF_RD_EN  out  1  read strobe (one cycle)
RF_WR_DATA  out  DATA_WIDTH  write data
ALU_FUN  out  ALU_FUN_WIDTH  ALU function, held through operation
ALU_EN  out  1  ALU start pulse (one cycle)
CLK_GATE_EN  out  1  ALU clock-gate enable
TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
TX_D_VLD  out  1  TX FIFO write strobe (one cycle)
CTRL_BUSY  out  1  high in every state except IDLE

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: every output is 0. State is IDLE.
- Reset asserted mid-command aborts the command. The next edge gives IDLE and all outputs 0. No partial write or push completes.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_PUSH, OPA, OPB, FUN, GATE, ALU_WAIT, PUSH_LO, PUSH_HI.
- IDLE, on RX_D_VLD:
  - 0xAA -> WR_ADDR
  - 0xBB -> RD_ADDR
  - 0xCC -> OPA
  - 0xDD -> FUN
  - Any other byte is ignored; stay in IDLE.
- WR_ADDR: RX_D_VLD latches RF_ADDR = RX_P_DATA[ADDR_WIDTH-1:0] -> WR_DATA.
- WR_DATA: RX_D_VLD -> next cycle RF_WR_EN=1 for exactly one cycle with RF_WR_DATA = byte -> IDLE.
- RD_ADDR: RX_D_VLD latches address -> next cycle RF_RD_EN=1 for one cycle -> RD_WAIT.
- RD_WAIT: on RF_RD_DATA_VLD, latch the data -> RD_PUSH.
- RD_PUSH: when FIFO_FULL=0, TX_D_VLD=1 for one cycle with the latched byte -> IDLE. While full, hold with TX_D_VLD=0.
- OPA: RX_D_VLD -> write strobe to address 0 with the byte -> OPB.
- OPB: RX_D_VLD -> write strobe to address 1 -> FUN. Operand writes use the same one-cycle-latency rule as WR_DATA.
- FUN: RX_D_VLD latches ALU_FUN = byte[ALU_FUN_WIDTH-1:0] and sets CLK_GATE_EN=1 -> GATE.
- GATE: ALU_EN=1 for one cycle (gate already open for one cycle) -> ALU_WAIT.
- ALU_WAIT: on ALU_OUT_VLD, latch the 16-bit result, CLK_GATE_EN=0 -> PUSH_LO.
- PUSH_LO: push result[7:0] when not full -> PUSH_HI.
- PUSH_HI: push result[15:8] when not full -> IDLE. Pushes are never back-to-back into a full FIFO.
- RX_D_VLD while in RD_WAIT, RD_PUSH, GATE, ALU_WAIT, PUSH_LO or PUSH_HI: the byte is dropped and the state is unchanged.
- No timeout: a missing RF_RD_DATA_VLD or ALU_OUT_VLD stalls until reset.
- An address byte wider than ADDR_WIDTH is truncated, no error.
- RX_D_VLD and FIFO_FULL deassertion arriving in the same cycle: only the current state's event is acted on.

Decomposition:
- Shared package sys_ctrl_pkg holds:
  - opcode constants CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD
  - state enum
  - ADDR_OPA=0, ADDR_OPB=1
- Main FSM stays in sys_cmd_ctrl.
- Optional sub-module sys_ctrl_tx_push: FIFO_FULL-aware one- or two-byte push sequencer used by RD_PUSH and PUSH_LO/HI.

Test Plan:
- AA,05,FF -> single RF_WR_EN pulse with RF_ADDR=5, RF_WR_DATA=0xFF; then IDLE, CTRL_BUSY=0.
- BB,02, RF returns 0x21 -> one RF_RD_EN pulse with RF_ADDR=2; one TX_D_VLD with TX_P_DATA=0x21.
- CC,0F,05,01, ALU returns 0x000A -> writes 0x0F@0 and 0x05@1, ALU_FUN=1; CLK_GATE_EN precedes ALU_EN by 1 cycle; pushes 0x0A then 0x00; gate closes after ALU_OUT_VLD.
- DD,00 with FIFO_FULL high for 5 cycles during PUSH_LO -> no TX_D_VLD while full; exactly two pushes (0x0A, 0x00) afterwards.
- Stray byte 0x3C in IDLE, and a byte sent during ALU_WAIT -> ignored; no strobes; sequence completes normally.
- RST pulsed after AA,05 (before data) -> next cycle all outputs 0, IDLE; following BB,05 behaves as a fresh read.
